axis_frame_gen: RTL and testbench

- Software-programmable AXI-Stream frame transmitter: drives one 16-bit AXIS ingress port of the packet filter with deterministic test frames.
- Used as the on-chip traffic source for bring-up and loopback of the filter's ingress/egress path.
- Configured and monitored through an Avalon-MM slave with read latency 1, plus a done interrupt.
- Keeps its own transmit counters so software can cross-check them against the filter's ingress counters.

---
 rtl/axis_frame_gen_pkg.sv | 41 ++++
 rtl/axis_frame_gen_csr.sv | 97 +++++++++
 rtl/axis_frame_gen.sv | 193 +++++++++++++++++++
 tb/tb_axis_frame_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_frame_gen_pkg.sv
// Shared definitions for the AXI-Stream frame generator: register map,
// CTRL bit positions, FSM states and the stream handshake types.
package axis_frame_gen_pkg;

    localparam int AXIS_DATA_W = 16;

    localparam logic [2:0] REG_CTRL         = 3'd0;
    localparam logic [2:0] REG_FRAME_LEN    = 3'd1;
    localparam logic [2:0] REG_NUM_FRAMES   = 3'd2;
    localparam logic [2:0] REG_GAP          = 3'd3;
    localparam logic [2:0] REG_SEED         = 3'd4;
    localparam logic [2:0] REG_TX_BEATS     = 3'd5;
    localparam logic [2:0] REG_TX_FRAMES    = 3'd6;
    localparam logic [2:0] REG_STALL_CYCLES = 3'd7;

    // Write-side CTRL bits
    localparam int CTRL_START    = 0;
    localparam int CTRL_ABORT    = 1;
    localparam int CTRL_DONE_CLR = 2;
    localparam int CTRL_IRQ_EN   = 3;
    // Read-side CTRL bits
    localparam int CTRL_BUSY     = 0;
    localparam int CTRL_DONE     = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic                   tvalid;
        logic                   tlast;
    } axis_source_t;

    typedef struct packed {
        logic tready;
    } axis_sink_t;

endpackage

// File: rtl/axis_frame_gen_csr.sv
// Avalon-MM register block for the frame generator: address decode, config
// registers, command pulses, registered readdata and the done interrupt.
module axis_frame_gen_csr
    import axis_frame_gen_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int GAP_WIDTH = 8,
    parameter int CTR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          writedata,
    input  logic                 write,
    input  logic                 chipselect,
    input  logic [7:0]           address,
    input  logic                 read,
    output logic [31:0]          readdata,
    output logic                 irq,
    input  logic                 busy,
    input  logic                 done,
    input  logic [CTR_WIDTH-1:0] tx_beats,
    input  logic [CTR_WIDTH-1:0] tx_frames,
    input  logic [CTR_WIDTH-1:0] stall_cycles,
    output logic                 start,
    output logic                 abort,
    output logic                 done_clr,
    output logic [LEN_WIDTH-1:0] frame_len,
    output logic [31:0]          num_frames,
    output logic [GAP_WIDTH-1:0] gap,
    output logic [15:0]          seed
);

    logic        sel;
    logic        ctrl_wr;
    logic        irq_en;
    logic [31:0] rd_mux;

    assign sel     = chipselect && (address[7:3] == 5'd0);
    assign ctrl_wr = sel && write && (address[2:0] == REG_CTRL);

    // Abort wins over start in the same write; both are meaningless in the wrong state.
    assign start    = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_ABORT] && !busy;
    assign abort    = ctrl_wr && writedata[CTRL_ABORT] && busy;
    assign done_clr = ctrl_wr && writedata[CTRL_DONE_CLR];
    assign irq      = done && irq_en;

    always_comb begin
        rd_mux = '0;
        case (address[2:0])
            REG_CTRL: begin
                rd_mux[CTRL_BUSY]   = busy;
                rd_mux[CTRL_DONE]   = done;
                rd_mux[CTRL_IRQ_EN] = irq_en;
            end
            REG_FRAME_LEN:    rd_mux = 32'(frame_len);
            REG_NUM_FRAMES:   rd_mux = num_frames;
            REG_GAP:          rd_mux = 32'(gap);
            REG_SEED:         rd_mux = 32'(seed);
            REG_TX_BEATS:     rd_mux = 32'(tx_beats);
            REG_TX_FRAMES:    rd_mux = 32'(tx_frames);
            REG_STALL_CYCLES: rd_mux = 32'(stall_cycles);
            default:          rd_mux = '0;
        endcase
        if (address[7:3] != 5'd0) begin
            rd_mux = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata   <= '0;
            irq_en     <= 1'b0;
            frame_len  <= '0;
            num_frames <= '0;
            gap        <= '0;
            seed       <= '0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= writedata[CTRL_IRQ_EN];
            end
            // Config is frozen while a run is in progress.
            if (sel && write && !busy) begin
                case (address[2:0])
                    REG_FRAME_LEN:  frame_len  <= writedata[LEN_WIDTH-1:0];
                    REG_NUM_FRAMES: num_frames <= writedata;
                    REG_GAP:        gap        <= writedata[GAP_WIDTH-1:0];
                    REG_SEED:       seed       <= writedata[15:0];
                    default:        ;
                endcase
            end
            if (sel && read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: rtl/axis_frame_gen.sv
// Programmable AXI-Stream test-frame source: sequences frames and gaps,
// generates deterministic payloads and keeps transmit statistics.
module axis_frame_gen
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8,
    parameter int CTR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           writedata,
    input  logic                  write,
    input  logic                  chipselect,
    input  logic [7:0]            address,
    input  logic                  read,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] tx_tdata,
    output logic                  tx_tvalid,
    input  logic                  tx_tready,
    output logic                  tx_tlast,
    output logic                  irq
);

    state_t                 state;
    axis_source_t           src;
    axis_sink_t             snk;

    logic                   start;
    logic                   abort;
    logic                   done_clr;
    logic                   done;
    logic [LEN_WIDTH-1:0]   frame_len;
    logic [31:0]            num_frames;
    logic [GAP_WIDTH-1:0]   gap;
    logic [15:0]            seed;

    logic [LEN_WIDTH-1:0]   len_w;
    logic [31:0]            num_w;
    logic [GAP_WIDTH-1:0]   gap_w;
    logic [15:0]            seed_w;
    logic [LEN_WIDTH-1:0]   beat;
    logic [31:0]            frame_idx;
    logic [GAP_WIDTH-1:0]   gap_cnt;
    logic                   abort_pend;
    logic [CTR_WIDTH-1:0]   tx_beats;
    logic [CTR_WIDTH-1:0]   tx_frames;
    logic [CTR_WIDTH-1:0]   stall_cycles;

    logic                   xfer;
    logic [LEN_WIDTH-1:0]   beat_nxt;
    logic [31:0]            frame_nxt;
    logic                   last_frame;
    logic [LEN_WIDTH-1:0]   eff_len;

    assign snk.tready = tx_tready;
    assign tx_tdata   = DATA_WIDTH'(src.tdata);
    assign tx_tvalid  = src.tvalid;
    assign tx_tlast   = src.tlast;

    assign xfer       = src.tvalid && snk.tready;
    assign beat_nxt   = beat + 1'b1;
    assign frame_nxt  = frame_idx + 32'd1;
    assign last_frame = (num_w != 32'd0) && (frame_nxt == num_w);
    assign eff_len    = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;

    axis_frame_gen_csr #(
        .LEN_WIDTH (LEN_WIDTH),
        .GAP_WIDTH (GAP_WIDTH),
        .CTR_WIDTH (CTR_WIDTH)
    ) u_csr (
        .clk          (clk),
        .reset        (reset),
        .writedata    (writedata),
        .write        (write),
        .chipselect   (chipselect),
        .address      (address),
        .read         (read),
        .readdata     (readdata),
        .irq          (irq),
        .busy         (state != ST_IDLE),
        .done         (done),
        .tx_beats     (tx_beats),
        .tx_frames    (tx_frames),
        .stall_cycles (stall_cycles),
        .start        (start),
        .abort        (abort),
        .done_clr     (done_clr),
        .frame_len    (frame_len),
        .num_frames   (num_frames),
        .gap          (gap),
        .seed         (seed)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            src          <= '0;
            done         <= 1'b0;
            len_w        <= '0;
            num_w        <= '0;
            gap_w        <= '0;
            seed_w       <= '0;
            beat         <= '0;
            frame_idx    <= '0;
            gap_cnt      <= '0;
            abort_pend   <= 1'b0;
            tx_beats     <= '0;
            tx_frames    <= '0;
            stall_cycles <= '0;
        end else begin
            // Clear first so a coincident completion below takes priority.
            if (done_clr) begin
                done <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_SEND;
                        len_w        <= eff_len;
                        num_w        <= num_frames;
                        gap_w        <= gap;
                        seed_w       <= seed;
                        beat         <= '0;
                        frame_idx    <= '0;
                        abort_pend   <= 1'b0;
                        tx_beats     <= '0;
                        tx_frames    <= '0;
                        stall_cycles <= '0;
                        done         <= 1'b0;
                        src.tvalid   <= 1'b1;
                        src.tdata    <= '0;
                        src.tlast    <= (eff_len == LEN_WIDTH'(1));
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        abort_pend <= 1'b1;
                    end
                    if (src.tvalid && !snk.tready) begin
                        stall_cycles <= stall_cycles + 1'b1;
                    end
                    if (xfer) begin
                        tx_beats <= tx_beats + 1'b1;
                        if (src.tlast) begin
                            tx_frames <= tx_frames + 1'b1;
                            frame_idx <= frame_nxt;
                            beat      <= '0;
                            if (last_frame || abort_pend || abort) begin
                                state <= ST_IDLE;
                                src   <= '0;
                                done  <= 1'b1;
                            end else if (gap_w == '0) begin
                                src.tdata <= AXIS_DATA_W'(frame_nxt);
                                src.tlast <= (len_w == LEN_WIDTH'(1));
                            end else begin
                                state      <= ST_GAP;
                                gap_cnt    <= gap_w;
                                src.tvalid <= 1'b0;
                                src.tlast  <= 1'b0;
                            end
                        end else begin
                            // Payload beats are seed-relative; beat 0 carries the frame index.
                            beat      <= beat_nxt;
                            src.tdata <= AXIS_DATA_W'(seed_w) + AXIS_DATA_W'(beat_nxt);
                            src.tlast <= (beat_nxt == len_w - 1'b1);
                        end
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        src   <= '0;
                        done  <= 1'b1;
                    end else if (gap_cnt <= GAP_WIDTH'(1)) begin
                        state      <= ST_SEND;
                        src.tvalid <= 1'b1;
                        src.tdata  <= AXIS_DATA_W'(frame_idx);
                        src.tlast  <= (len_w == LEN_WIDTH'(1));
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    src   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed bench for axis_frame_gen: scoreboarded stream beats, gap and
// stall monitoring, and register readback of the statistics counters.
module tb_axis_frame_gen;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] writedata = '0;
    logic        write = 1'b0;
    logic        chipselect = 1'b0;
    logic [7:0]  address = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic [15:0] tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready = 1'b1;
    logic        tx_tlast;
    logic        irq;

    int tests = 0;
    int fails = 0;

    logic [16:0] exp_q[$];
    int          gaps_q[$];
    bit          gap_counting = 1'b0;
    int          gap_len = 0;
    bit          stall_prev = 1'b0;
    logic [16:0] stall_word = '0;

    axis_frame_gen #(
        .DATA_WIDTH (16),
        .LEN_WIDTH  (16),
        .GAP_WIDTH  (8),
        .CTR_WIDTH  (32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .writedata  (writedata),
        .write      (write),
        .chipselect (chipselect),
        .address    (address),
        .read       (read),
        .readdata   (readdata),
        .tx_tdata   (tx_tdata),
        .tx_tvalid  (tx_tvalid),
        .tx_tready  (tx_tready),
        .tx_tlast   (tx_tlast),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: beats against the scoreboard, hold during stalls, gap lengths.
    always @(negedge clk) begin
        if (reset) begin
            if (stall_prev && tx_tvalid) begin
                check("stall_hold", {15'd0, tx_tlast, tx_tdata}, {15'd0, stall_word});
            end
            stall_prev = tx_tvalid && !tx_tready;
            stall_word = {tx_tlast, tx_tdata};
            if (gap_counting && tx_tvalid) begin
                gaps_q.push_back(gap_len);
                gap_counting = 1'b0;
            end else if (gap_counting) begin
                gap_len++;
            end
            if (tx_tvalid && tx_tready) begin
                tests++;
                assert (exp_q.size() != 0) else begin
                    fails++;
                    $error("FAIL sb_extra: observed beat 0x%0h expected no beat", {tx_tlast, tx_tdata});
                end
                if (exp_q.size() != 0) begin
                    check("sb_beat", {15'd0, tx_tlast, tx_tdata}, {15'd0, exp_q.pop_front()});
                end
                if (tx_tlast) begin
                    gap_counting = 1'b1;
                    gap_len = 0;
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0; address = '0;
        d = readdata;
    endtask

    task automatic expect_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        bus_read(a, r);
        check(tag, r, exp);
    endtask

    task automatic cfg(input int len, input int num, input int gp, input logic [15:0] sd);
        bus_write(8'd1, 32'(len));
        bus_write(8'd2, 32'(num));
        bus_write(8'd3, 32'(gp));
        bus_write(8'd4, {16'd0, sd});
    endtask

    task automatic push_frames(input int len, input int num, input logic [15:0] sd);
        int l;
        logic [16:0] w;
        l = (len == 0) ? 1 : len;
        for (int f = 0; f < num; f++) begin
            for (int k = 0; k < l; k++) begin
                w[15:0] = (k == 0) ? 16'(f) : 16'(sd + 16'(k));
                w[16]   = (k == l - 1);
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic clear_gaps();
        gap_counting = 1'b0;
        gaps_q.delete();
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] r;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            bus_read(8'd0, r);
            if (r[1]) ok = 1'b1;
        end
        check(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_readdata", readdata, 32'd0);
        check("rst_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check("rst_tlast", {31'd0, tx_tlast}, 32'd0);
        check("rst_tdata", {16'd0, tx_tdata}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        #10 reset = 1'b1;
        expect_reg("rst_frame_len", 8'd1, 32'd0);
        expect_reg("rst_tx_beats", 8'd5, 32'd0);
        expect_reg("rst_ctrl", 8'd0, 32'd0);
        expect_reg("bad_addr", 8'h09, 32'd0);

        // Two back-to-back 4-beat frames
        cfg(4, 2, 0, 16'h0100);
        push_frames(4, 2, 16'h0100);
        clear_gaps();
        bus_write(8'd0, 32'h1);
        check("t1_latency", {31'd0, tx_tvalid}, 32'd1);
        check("t1_beat0", {16'd0, tx_tdata}, 32'd0);
        wait_done("t1_done");
        check("t1_drained", exp_q.size(), 32'd0);
        check("t1_gaps", gaps_q.size(), 32'd1);
        check("t1_no_bubble", (gaps_q.size() > 0) ? gaps_q[0] : -1, 32'd0);
        expect_reg("t1_tx_beats", 8'd5, 32'd8);
        expect_reg("t1_tx_frames", 8'd6, 32'd2);
        expect_reg("t1_ctrl", 8'd0, 32'h2);

        // Five-cycle stall on beat 1
        cfg(3, 1, 0, 16'h2000);
        push_frames(3, 1, 16'h2000);
        bus_write(8'd0, 32'h1);
        @(posedge clk); #1;
        tx_tready = 1'b0;
        check("t2_stall_data", {16'd0, tx_tdata}, 32'h2001);
        repeat (5) @(posedge clk);
        #1;
        tx_tready = 1'b1;
        wait_done("t2_done");
        check("t2_drained", exp_q.size(), 32'd0);
        expect_reg("t2_stall", 8'd7, 32'd5);
        expect_reg("t2_tx_beats", 8'd5, 32'd3);

        // Inter-frame gap of 4
        cfg(2, 3, 4, 16'h0030);
        push_frames(2, 3, 16'h0030);
        clear_gaps();
        bus_write(8'd0, 32'h1);
        wait_done("t3_done");
        check("t3_drained", exp_q.size(), 32'd0);
        check("t3_gaps", gaps_q.size(), 32'd2);
        check("t3_gap0", (gaps_q.size() > 0) ? gaps_q[0] : -1, 32'd4);
        check("t3_gap1", (gaps_q.size() > 1) ? gaps_q[1] : -1, 32'd4);
        expect_reg("t3_tx_frames", 8'd6, 32'd3);

        // Continuous run aborted during beat 2 of frame 0
        cfg(5, 0, 0, 16'h4000);
        push_frames(5, 1, 16'h4000);
        bus_write(8'd0, 32'h1);
        @(posedge clk);
        bus_write(8'd0, 32'h2);
        wait_done("t4_done");
        check("t4_drained", exp_q.size(), 32'd0);
        check("t4_tvalid_off", {31'd0, tx_tvalid}, 32'd0);
        expect_reg("t4_tx_beats", 8'd5, 32'd5);
        expect_reg("t4_ctrl", 8'd0, 32'h2);

        // Zero length means one beat; irq and busy-time config lockout
        cfg(0, 1, 0, 16'h0000);
        tx_tready = 1'b0;
        push_frames(0, 1, 16'h0000);
        bus_write(8'd0, 32'h9);
        check("t5_tlast", {31'd0, tx_tlast}, 32'd1);
        check("t5_irq_busy", {31'd0, irq}, 32'd0);
        bus_write(8'd1, 32'd7);
        expect_reg("t5_len_locked", 8'd1, 32'd0);
        tx_tready = 1'b1;
        wait_done("t5_done");
        check("t5_irq_set", {31'd0, irq}, 32'd1);
        bus_write(8'd0, 32'hC);
        check("t5_irq_clr", {31'd0, irq}, 32'd0);
        expect_reg("t5_ctrl", 8'd0, 32'h8);
        check("t5_drained", exp_q.size(), 32'd0);

        // Asynchronous reset mid-frame, then a normal run
        cfg(8, 1, 0, 16'h0600);
        push_frames(8, 1, 16'h0600);
        bus_write(8'd0, 32'h1);
        @(posedge clk); #3;
        check("t6_pre_tvalid", {31'd0, tx_tvalid}, 32'd1);
        reset = 1'b0;
        #1;
        check("t6_async_tvalid", {31'd0, tx_tvalid}, 32'd0);
        check("t6_async_tlast", {31'd0, tx_tlast}, 32'd0);
        check("t6_async_readdata", readdata, 32'd0);
        exp_q.delete();
        clear_gaps();
        #20 reset = 1'b1;
        expect_reg("t6_frame_len", 8'd1, 32'd0);
        expect_reg("t6_num_frames", 8'd2, 32'd0);
        expect_reg("t6_seed", 8'd4, 32'd0);
        expect_reg("t6_tx_beats", 8'd5, 32'd0);
        expect_reg("t6_ctrl", 8'd0, 32'd0);
        cfg(2, 1, 0, 16'h0055);
        push_frames(2, 1, 16'h0055);
        bus_write(8'd0, 32'h1);
        wait_done("t6_done");
        check("t6_drained", exp_q.size(), 32'd0);
        expect_reg("t6_tx_beats_run", 8'd5, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
